// File: rtl/capi_command_arbiter.sv
// Round-robin share of the PSL command bus among NUM_REQ engines, with room credits, tag ranges and odd parity.
// command_out is registered one cycle after req_grant; grants stop whenever credits run out or the job is not running.
module capi_command_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int CREDIT_W = 9
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic                  job_start,
  input  logic                  job_reset,
  input  logic [7:0]            command_in,
  input  logic [26:0]           response_in,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_is_write,
  input  logic [NUM_REQ*13-1:0] req_command,
  input  logic [NUM_REQ*64-1:0] req_address,
  input  logic [NUM_REQ*12-1:0] req_size,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [119:0]          command_out,
  output logic [CREDIT_W-1:0]   credits,
  output logic [7:0]            outstanding,
  output logic                  idle
);

  // response_in = {valid, tag[7:0], tag_par, response[7:0], credits[8:0]}
  // command_out = {valid, tag[7:0], tag_par, command[12:0], cmd_par, abt[2:0], address[63:0], addr_par, ctx[15:0], size[11:0]}
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0] READ_TAG_BASE  = 8'h50;
  localparam logic [7:0] TAG_UPPER      = 8'hFF;
  localparam logic [7:0] WRITE_TAG_BASE = 8'h03;
  localparam logic [7:0] WRITE_TAG_TOP  = 8'h4F;
  localparam logic [2:0] ABT_STRICT     = 3'b000;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   run_en;

  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [7:0]          outstanding_q, outstanding_d;
  logic [7:0]          read_tag_q, read_tag_d;
  logic [7:0]          write_tag_q, write_tag_d;
  logic [IDX_W-1:0]    rr_q, rr_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W:0]     sum;
  logic               issue;

  logic        resp_valid;
  logic [7:0]  resp_tag;
  logic        resp_count;
  logic        unused_resp;

  logic [12:0] cmd_arr  [NUM_REQ];
  logic [63:0] addr_arr [NUM_REQ];
  logic [11:0] size_arr [NUM_REQ];

  logic        sel_is_write;
  logic [7:0]  sel_tag;

  logic        out_valid_q;
  logic [7:0]  out_tag_q;
  logic        out_tag_par_q;
  logic [12:0] out_cmd_q;
  logic        out_cmd_par_q;
  logic [63:0] out_addr_q;
  logic        out_addr_par_q;
  logic [11:0] out_size_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cmd_arr[g]  = req_command[g*13 +: 13];
    assign addr_arr[g] = req_address[g*64 +: 64];
    assign size_arr[g] = req_size[g*12 +: 12];
  end

  assign resp_valid  = response_in[26];
  assign resp_tag    = response_in[25:18];
  assign unused_resp = ^response_in[17:0];
  assign resp_count  = resp_valid && (resp_tag >= WRITE_TAG_BASE) && (state_q != S_IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (job_start && !job_reset) state_d = S_RUN;
      S_RUN:   if (job_reset) state_d = S_DRAIN;
      S_DRAIN: if (outstanding_q == 8'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle   = (state_q == S_IDLE);
    run_en = (state_q == S_RUN);
  end

  // ---------------- arbitration ----------------
  assign eligible = (run_en && (credits_q != '0)) ? req_valid : '0;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (!found && eligible[sum[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[IDX_W-1:0];
      end
    end
  end

  assign issue        = found;
  assign req_grant    = issue ? (NUM_REQ'(1) << winner) : '0;
  assign sel_is_write = req_is_write[winner];
  assign sel_tag      = sel_is_write ? write_tag_q : read_tag_q;

  // ---------------- counters and tags ----------------
  always_comb begin
    credits_d     = credits_q;
    outstanding_d = outstanding_q;
    read_tag_d    = read_tag_q;
    write_tag_d   = write_tag_q;
    rr_d          = rr_q;

    if (state_q == S_IDLE) begin
      if (job_reset)      credits_d = '0;
      else if (job_start) credits_d = CREDIT_W'(command_in);
    end else if (issue && !resp_count) begin
      credits_d = credits_q - 1'b1;
    end else if (!issue && resp_count && (credits_q != CREDIT_MAX)) begin
      credits_d = credits_q + 1'b1;
    end

    if (issue && !resp_count && (outstanding_q != 8'hFF)) outstanding_d = outstanding_q + 8'd1;
    else if (!issue && resp_count && (outstanding_q != 8'h00)) outstanding_d = outstanding_q - 8'd1;

    if (issue) begin
      rr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
      if (sel_is_write) write_tag_d = (write_tag_q == WRITE_TAG_TOP) ? WRITE_TAG_BASE : write_tag_q + 8'd1;
      else              read_tag_d  = (read_tag_q == TAG_UPPER) ? READ_TAG_BASE : read_tag_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      credits_q     <= '0;
      outstanding_q <= '0;
      read_tag_q    <= READ_TAG_BASE;
      write_tag_q   <= WRITE_TAG_BASE;
      rr_q          <= '0;
    end else begin
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      read_tag_q    <= read_tag_d;
      write_tag_q   <= write_tag_d;
      rr_q          <= rr_d;
    end
  end

  // Fields hold their last issued value; only valid pulses.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      out_valid_q    <= 1'b0;
      out_tag_q      <= '0;
      out_tag_par_q  <= 1'b0;
      out_cmd_q      <= '0;
      out_cmd_par_q  <= 1'b0;
      out_addr_q     <= '0;
      out_addr_par_q <= 1'b0;
      out_size_q     <= '0;
    end else begin
      out_valid_q <= issue;
      if (issue) begin
        out_tag_q      <= sel_tag;
        out_tag_par_q  <= ~^sel_tag;
        out_cmd_q      <= cmd_arr[winner];
        out_cmd_par_q  <= ~^cmd_arr[winner];
        out_addr_q     <= addr_arr[winner];
        out_addr_par_q <= ~^addr_arr[winner];
        out_size_q     <= size_arr[winner];
      end
    end
  end

  assign command_out = {out_valid_q, out_tag_q, out_tag_par_q, out_cmd_q, out_cmd_par_q,
                        ABT_STRICT, out_addr_q, out_addr_par_q, 16'h0000, out_size_q};
  assign credits     = credits_q;
  assign outstanding = outstanding_q;

endmodule
